// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Captures decoded ID fields, sign-extends the immediate, decodes EX/MEM controls and counts stall cycles.
module id_ex_pipe_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7b5,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [11:0]      id_imm12,
    input  logic             stall,
    input  logic             flush,
    input  logic             wb_we,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [6:0]       ex_opcode,
    output logic [4:0]       ex_rd,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_alu_src_imm,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            alu_src_imm;
        logic            illegal;
    } ex_t;

    ex_t              ex_d, ex_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic             wb_live;

    assign wb_live = wb_we && (wb_rd != 5'd0);

    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (stall) begin
            // A held instruction must still see writebacks that retire while it waits.
            if (ex_q.valid && wb_live && (wb_rd == ex_q.rs1)) ex_d.rs1_data = wb_data;
            if (ex_q.valid && wb_live && (wb_rd == ex_q.rs2)) ex_d.rs2_data = wb_data;
        end else begin
            ex_d.valid       = id_valid;
            ex_d.pc          = id_pc;
            ex_d.opcode      = id_opcode;
            ex_d.rd          = id_rd;
            ex_d.rs1         = id_rs1;
            ex_d.rs2         = id_rs2;
            ex_d.funct3      = id_funct3;
            ex_d.funct7b5    = id_funct7b5;
            ex_d.rs1_data    = (wb_live && (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
            ex_d.rs2_data    = (wb_live && (wb_rd == id_rs2)) ? wb_data : id_rs2_data;
            ex_d.imm         = {{(XLEN-12){id_imm12[11]}}, id_imm12};
            ex_d.reg_write   = 1'b0;
            ex_d.mem_read    = 1'b0;
            ex_d.mem_write   = 1'b0;
            ex_d.alu_src_imm = 1'b0;
            ex_d.illegal     = 1'b0;
            case (id_opcode)
                OPC_LOAD: begin
                    ex_d.reg_write   = 1'b1;
                    ex_d.mem_read    = 1'b1;
                    ex_d.alu_src_imm = 1'b1;
                end
                OPC_OP_IMM: begin
                    ex_d.reg_write   = 1'b1;
                    ex_d.alu_src_imm = 1'b1;
                end
                OPC_STORE: begin
                    ex_d.mem_write   = 1'b1;
                    ex_d.alu_src_imm = 1'b1;
                end
                OPC_OP:  ex_d.reg_write = 1'b1;
                default: ex_d.illegal   = 1'b1;
            endcase
            if (!id_valid) begin
                ex_d.reg_write   = 1'b0;
                ex_d.mem_read    = 1'b0;
                ex_d.mem_write   = 1'b0;
                ex_d.alu_src_imm = 1'b0;
                ex_d.illegal     = 1'b0;
            end
            if (id_rd == 5'd0) ex_d.reg_write = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid       = ex_q.valid;
    assign ex_pc          = ex_q.pc;
    assign ex_opcode      = ex_q.opcode;
    assign ex_rd          = ex_q.rd;
    assign ex_rs1         = ex_q.rs1;
    assign ex_rs2         = ex_q.rs2;
    assign ex_funct3      = ex_q.funct3;
    assign ex_funct7b5    = ex_q.funct7b5;
    assign ex_rs1_data    = ex_q.rs1_data;
    assign ex_rs2_data    = ex_q.rs2_data;
    assign ex_imm         = ex_q.imm;
    assign ex_reg_write   = ex_q.reg_write;
    assign ex_mem_read    = ex_q.mem_read;
    assign ex_mem_write   = ex_q.mem_write;
    assign ex_alu_src_imm = ex_q.alu_src_imm;
    assign ex_illegal     = ex_q.illegal;
    assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: a vector table for single-cycle loads plus
// hand-written stall, flush, reset and saturation sequences.
module tb_id_ex_pipe_reg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc;
    logic [6:0]       id_opcode;
    logic [4:0]       id_rd, id_rs1, id_rs2;
    logic [2:0]       id_funct3;
    logic             id_funct7b5;
    logic [XLEN-1:0]  id_rs1_data, id_rs2_data;
    logic [11:0]      id_imm12;
    logic             stall, flush;
    logic             wb_we;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [6:0]       ex_opcode;
    logic [4:0]       ex_rd, ex_rs1, ex_rs2;
    logic [2:0]       ex_funct3;
    logic             ex_funct7b5;
    logic [XLEN-1:0]  ex_rs1_data, ex_rs2_data, ex_imm;
    logic             ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src_imm, ex_illegal;
    logic [CNT_W-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm12(id_imm12), .stall(stall), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode),
        .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_alu_src_imm(ex_alu_src_imm), .ex_illegal(ex_illegal),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  funct3;
        logic [11:0] imm12;
        logic [31:0] rs1_data, rs2_data;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [31:0] e_imm, e_rs1_data, e_rs2_data;
        logic [4:0]  e_ctl; // {reg_write, mem_read, mem_write, alu_src_imm, illegal}
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc, input logic [6:0] opc,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [2:0] f3, input logic [11:0] imm,
                            input logic [31:0] d1, input logic [31:0] d2);
        id_valid = v; id_pc = pc; id_opcode = opc; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_funct3 = f3; id_funct7b5 = f3[0]; id_imm12 = imm; id_rs1_data = d1; id_rs2_data = d2;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
        wb_we = we; wb_rd = rd; wb_data = d;
    endtask

    function automatic logic [4:0] ctl();
        return {ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src_imm, ex_illegal};
    endfunction

    initial begin
        //            name          v  pc      opc        rd  rs1 rs2 f3 imm12  rs1d     rs2d    we rd  wbdata   e_imm        e_rs1    e_rs2    ctl
        vecs[0] = '{"load",        1, 32'h40, 7'h03,     5,  1,  2, 2, 12'hFFC, 32'h100, 32'h200, 0, 0, 32'h0,  32'hFFFFFFFC, 32'h100, 32'h200, 5'b11010};
        vecs[1] = '{"store_rd0",   1, 32'h44, 7'h23,     0,  3,  4, 2, 12'h7FF, 32'h10,  32'h20,  0, 0, 32'h0,  32'h000007FF, 32'h10,  32'h20,  5'b00110};
        vecs[2] = '{"op_rd0",      1, 32'h48, 7'h33,     0,  5,  6, 0, 12'h800, 32'h1,   32'h2,   0, 0, 32'h0,  32'hFFFFF800, 32'h1,   32'h2,   5'b00000};
        vecs[3] = '{"op_rd4",      1, 32'h4C, 7'h33,     4,  5,  6, 7, 12'h000, 32'h3,   32'h4,   0, 0, 32'h0,  32'h00000000, 32'h3,   32'h4,   5'b10000};
        vecs[4] = '{"cap_byp",     1, 32'h50, 7'h13,     8,  7,  7, 1, 12'h001, 32'h1,   32'h2,   1, 7, 32'h55, 32'h00000001, 32'h55,  32'h55,  5'b10010};
        vecs[5] = '{"cap_x0",      1, 32'h54, 7'h13,     8,  0,  0, 1, 12'h002, 32'h11,  32'h12,  1, 0, 32'h99, 32'h00000002, 32'h11,  32'h12,  5'b10010};
        vecs[6] = '{"cap_nowe",    1, 32'h58, 7'h33,     9,  7,  8, 0, 12'h003, 32'h21,  32'h22,  0, 7, 32'h77, 32'h00000003, 32'h21,  32'h22,  5'b10000};
        vecs[7] = '{"illegal_v1",  1, 32'h5C, 7'b1110011, 1, 0,  0, 0, 12'h000, 32'h0,   32'h0,   0, 0, 32'h0,  32'h00000000, 32'h0,   32'h0,   5'b00001};
        vecs[8] = '{"illegal_v0",  0, 32'h60, 7'b1110011, 1, 0,  0, 0, 12'h000, 32'h0,   32'h0,   0, 0, 32'h0,  32'h00000000, 32'h0,   32'h0,   5'b00000};

        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive_id(1, 32'hAAAA, 7'h33, 3, 1, 2, 5, 12'h123, 32'h1234, 32'h5678);
        wb(1, 1, 32'hFFFF);
        tick(); tick();
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_imm", ex_imm, 32'd0);
        chk("rst_ctl", {27'd0, ctl()}, 32'd0);
        chk("rst_cnt", {28'd0, stall_cnt}, 32'd0);
        rst = 1'b0;
        wb(0, 0, 0);

        for (int i = 0; i < 9; i++) begin
            drive_id(vecs[i].valid, vecs[i].pc, vecs[i].opcode, vecs[i].rd, vecs[i].rs1,
                     vecs[i].rs2, vecs[i].funct3, vecs[i].imm12, vecs[i].rs1_data, vecs[i].rs2_data);
            wb(vecs[i].wb_we, vecs[i].wb_rd, vecs[i].wb_data);
            tick();
            chk({vecs[i].name, "_valid"}, {31'd0, ex_valid}, {31'd0, vecs[i].valid});
            chk({vecs[i].name, "_pc"}, ex_pc, vecs[i].pc);
            chk({vecs[i].name, "_rd"}, {27'd0, ex_rd}, {27'd0, vecs[i].rd});
            chk({vecs[i].name, "_f3"}, {29'd0, ex_funct3}, {29'd0, vecs[i].funct3});
            chk({vecs[i].name, "_imm"}, ex_imm, vecs[i].e_imm);
            chk({vecs[i].name, "_rs1d"}, ex_rs1_data, vecs[i].e_rs1_data);
            chk({vecs[i].name, "_rs2d"}, ex_rs2_data, vecs[i].e_rs2_data);
            chk({vecs[i].name, "_ctl"}, {27'd0, ctl()}, {27'd0, vecs[i].e_ctl});
        end
        wb(0, 0, 0);

        // Hold OP_IMM (rs1=3) for three stalled edges; WB writes x3 on the second.
        rst = 1'b1; tick(); rst = 1'b0;
        drive_id(1, 32'h100, 7'h13, 9, 3, 4, 0, 12'h010, 32'h1, 32'h2);
        tick();
        stall = 1'b1;
        drive_id(1, 32'h999, 7'h23, 1, 10, 11, 6, 12'hABC, 32'hBAD, 32'hBAD);
        tick();
        wb(1, 3, 32'hDEADBEEF); tick();
        wb(0, 3, 32'h0); tick();
        chk("hold_rs1d", ex_rs1_data, 32'hDEADBEEF);
        chk("hold_rs2d", ex_rs2_data, 32'h2);
        chk("hold_imm", ex_imm, 32'h10);
        chk("hold_pc", ex_pc, 32'h100);
        chk("hold_rs1", {27'd0, ex_rs1}, 32'd3);
        chk("hold_ctl", {27'd0, ctl()}, {27'd0, 5'b10010});
        chk("hold_cnt", {28'd0, stall_cnt}, 32'd3);

        // Same hold with rs1=x0 and a WB to x0: nothing may change.
        stall = 1'b0;
        drive_id(1, 32'h104, 7'h13, 9, 0, 4, 0, 12'h010, 32'h0, 32'h2);
        tick();
        stall = 1'b1;
        tick();
        wb(1, 0, 32'hDEADBEEF); tick();
        wb(0, 0, 32'h0); tick();
        chk("hold_x0_rs1d", ex_rs1_data, 32'h0);
        chk("hold_x0_pc", ex_pc, 32'h104);
        chk("hold_x0_cnt", {28'd0, stall_cnt}, 32'd6);

        // Flush with stall: bubble wins, counter still counts.
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_ctl", {27'd0, ctl()}, 32'd0);
        chk("flush_imm", ex_imm, 32'd0);
        chk("flush_rs2d", ex_rs2_data, 32'd0);
        chk("flush_cnt", {28'd0, stall_cnt}, 32'd7);

        // Reset during a stall clears both pipeline and counter.
        stall = 1'b0;
        drive_id(1, 32'h200, 7'h03, 5, 1, 2, 2, 12'hFFC, 32'h100, 32'h200);
        tick();
        chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        stall = 1'b1; rst = 1'b1; tick(); rst = 1'b0; stall = 1'b0;
        chk("rst_stall_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_stall_rs1d", ex_rs1_data, 32'd0);
        chk("rst_stall_ctl", {27'd0, ctl()}, 32'd0);
        chk("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);

        // Saturation of the 4-bit counter.
        stall = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("cnt_14", {28'd0, stall_cnt}, 32'd14);
        tick();
        chk("cnt_15", {28'd0, stall_cnt}, 32'd15);
        tick(); tick();
        chk("cnt_sat", {28'd0, stall_cnt}, 32'd15);
        stall = 1'b0;
        tick();
        chk("cnt_keep", {28'd0, stall_cnt}, 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
